mmu_access_ctrl: RTL
====================

// Module: mmu_access_ctrl
// PURPOSE
//  Sequencer for the two-phase MMU. Drives phase/E into the MMU, consumes its translated word address ma and runs the memory handshake.
//  Phase 0: fetches the PTE at ma and returns it to the MMU on mout. Phase 1: performs the translated access.
//  Checks PTE valid/write bits and raises page-fault or bus-error. Sits between the CPU memory stage and main memory.
// PARAMETERS
//  AW       30  word-address width (byte address bits [31:2])
//  DW       32  data / PTE width
//  TIMEOUT  15  max cycles mem_req may wait for mem_ack before bus error (>=1)
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous reset, active low
//  req        in   1   access request from CPU; sampled only in IDLE
//  is_fetch   in   1   1 = fetch (pc, E=0); 0 = data (ea, E=1)
//  wr         in   1   1 = data write (ignored when is_fetch=1)
//  wdata      in   DW  write data, captured on accept
//  mode       in   1   1 = user (translate); 0 = system (single phase)
//  ma         in   AW  translated address from MMU (combinational on phase/E)
//  phase      out  1   MMU phase select
//  E          out  1   MMU source select
//  mout       out  DW  latched PTE to MMU
//  mem_req    out  1   memory request; held with stable address until ack
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory address (= ma while mem_req=1)
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data, valid with mem_ack
//  mem_ack    in   1   memory acknowledge; may assert in same cycle as mem_req
//  busy       out  1   1 whenever state != IDLE
//  done       out  1   1-cycle pulse: access completed
//  rdata      out  DW  read data; valid from done until next accept
//  pf         out  1   1-cycle pulse: page fault
//  berr       out  1   1-cycle pulse: memory timeout
// BEHAVIOUR
//  Reset (async): all outputs 0; state=IDLE; mem_req drops immediately.
//   Reset mid-operation abandons the access; no done/pf/berr is issued.
//  PTE format: [31:12] ppx, [11] valid, [10] writable, [9:0] ignored.
//  States:
//   IDLE:   req=1 -> capture is_fetch/wr/wdata/mode; E<=~is_fetch.
//           mode=1 -> PTE (phase<=0); mode=0 -> ACC (phase<=1).
//   PTE:    mem_req=1, mem_we=0. On mem_ack: mout<=mem_rdata.
//           valid=0, or (wr & ~is_fetch & writable=0) -> FAULT; else -> ACC with phase<=1.
//   ACC:    mem_req=1, mem_we=wr&~is_fetch, mem_wdata=captured wdata.
//           On mem_ack: rdata<=mem_rdata (reads only; writes keep rdata) -> DONE.
//   DONE:   done=1 for one cycle -> IDLE.
//   FAULT:  pf=1 for one cycle -> IDLE; no phase-1 access is issued.
//   BERR:   berr=1 for one cycle -> IDLE.
//  Timeout: counter clears on entry to PTE/ACC and increments per cycle with no ack.
//   At count==TIMEOUT with no ack: drop mem_req, go to BERR. An ack in that same cycle wins.
//  Latency (zero-wait memory, req accepted in cycle 0): user done in cycle 3; system done in cycle 2.
//   Each wait cycle adds 1.
//  req while busy is ignored (not queued). CPU holds pc/ea stable while busy=1.
//  mem_ack outside PTE/ACC is ignored. phase and E hold their values in IDLE.
//  mout retains the last PTE across accesses and system-mode accesses.
// TESTING
//  1 User read, zero-wait: mode=1, is_fetch=1, PTE 0x00005C00, data 0xDEADBEEF
//    -> phase 0 then 1, E=0, mout=0x00005C00, done in cycle 3, rdata=0xDEADBEEF.
//  2 Invalid PTE 0x00005000 -> pf pulses 1 cycle, one mem_req only, done never 1, mem_we never 1.
//  3 Data write (is_fetch=0, wr=1, wdata=0x12345678), PTE 0x00005800 (read-only) -> pf; mem_we stays 0.
//    Same with PTE 0x00005C00 -> E=1, second req with mem_we=1, mem_wdata=0x12345678, done.
//  4 System mode, mode=0: single request with phase=1, done in cycle 2.
//    3 ack wait states -> mem_addr stable for all 4 request cycles, done in cycle 5.
//  5 mem_ack held 0 -> mem_req high for TIMEOUT+1 cycles, then berr pulse, busy=0.
//    Ack on the final cycle -> done, not berr.
//  6 rst_n low while waiting in PTE -> mem_req=0 immediately, all outputs 0.
//    After release, a fresh req completes normally.

Source files
------------

// File: rtl/mmu_access_ctrl.sv
// Two-phase MMU access sequencer.
// Optional PTE fetch (phase 0), then the translated access (phase 1).
// Checks PTE valid/writable bits and enforces a bounded memory-ack wait.
module mmu_access_ctrl #(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          is_fetch,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          mode,
  input  logic [AW-1:0] ma,
  output logic          phase,
  output logic          E,
  output logic [DW-1:0] mout,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          pf,
  output logic          berr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PTE,
    S_ACC,
    S_DONE,
    S_FAULT,
    S_BERR
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_fetch;
  logic            r_wr;
  logic            r_phase;
  logic            r_e;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_mout;
  logic [DW-1:0]   r_rdata;
  logic [CW-1:0]   r_cnt;
  logic            w_is_write;
  logic            w_pte_ok;
  logic            w_timeout;
  logic            w_in_mem;

  // A data write needs the writable bit; fetches and reads only need valid.
  assign w_is_write = r_wr & ~r_fetch;
  assign w_pte_ok   = mem_rdata[11] & ~(w_is_write & ~mem_rdata[10]);
  assign w_in_mem   = (r_state == S_PTE) || (r_state == S_ACC);
  // An ack arriving in the final allowed cycle still completes the access.
  assign w_timeout  = (r_cnt == CW'(TIMEOUT)) && !mem_ack;

  // State register; async reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req) w_next = mode ? S_PTE : S_ACC;
      S_PTE: begin
        if (mem_ack)        w_next = w_pte_ok ? S_ACC : S_FAULT;
        else if (w_timeout) w_next = S_BERR;
      end
      S_ACC: begin
        if (mem_ack)        w_next = S_DONE;
        else if (w_timeout) w_next = S_BERR;
      end
      S_DONE:  w_next = S_IDLE;
      S_FAULT: w_next = S_IDLE;
      S_BERR:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Wait counter: restarts on every entry into a memory phase, counts unacked cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     r_cnt <= '0;
    else if (w_next != r_state)                     r_cnt <= '0;
    else if (w_in_mem && !mem_ack && !w_timeout)    r_cnt <= r_cnt + 1'b1;
  end

  // Request capture, MMU phase/source select, PTE latch and read-data latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch <= 1'b0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
      r_phase <= 1'b0;
      r_e     <= 1'b0;
      r_mout  <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_fetch <= is_fetch;
            r_wr    <= wr;
            r_wdata <= wdata;
            r_e     <= ~is_fetch;
            r_phase <= ~mode;
          end
        end
        S_PTE: begin
          if (mem_ack) begin
            r_mout <= mem_rdata;
            if (w_pte_ok) r_phase <= 1'b1;
          end
        end
        S_ACC: begin
          if (mem_ack && !w_is_write) r_rdata <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign phase     = r_phase;
  assign E         = r_e;
  assign mout      = r_mout;
  assign mem_req   = w_in_mem;
  assign mem_we    = (r_state == S_ACC) && w_is_write;
  assign mem_addr  = w_in_mem ? ma : '0;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign pf        = (r_state == S_FAULT);
  assign berr      = (r_state == S_BERR);
  assign rdata     = r_rdata;

endmodule
